// File: rtl/lightgun_hv_latch_pkg.sv
// Shared types and widths for the light gun HV latch.
package lightgun_hv_latch_pkg;

    localparam int HCNT_W = 9;
    localparam int VCNT_W = 9;
    localparam int HV_W   = 16;

    // Latch FSM: DISABLED follows LATCH_EN low, ARMED waits for a sensor
    // edge, CAPTURED holds the frozen beam position until the CPU reads it.
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        CAPTURED = 2'd2
    } lg_state_t;

endpackage

// File: rtl/lightgun_hv_latch_sync_rise.sv
// Synchronizer for the asynchronous light gun sensor plus a rising-edge
// detector. Every flop resets to 1 so a sensor that is already lit when
// reset releases does not look like a fresh hit.
module sync_rise #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SENSOR,
    output logic SEN_EDGE
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the sensor through the synchronizer chain and keep one history bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], SENSOR};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign SEN_EDGE = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/lightgun_hv_latch.sv
// Light gun HV latch: beam counters, sensor-triggered position capture,
// missed-hit counter and the external interrupt request.
module lightgun_hv_latch
    import lightgun_hv_latch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MISS_W      = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE_PIX,
    input  logic              HDE,
    input  logic              VDE,
    input  logic              SENSOR,
    input  logic              LATCH_EN,
    input  logic              IE2,
    input  logic              HV_RD,
    input  logic              INT_ACK,
    output logic [15:0]       HV_OUT,
    output logic              EXINT,
    output logic              LATCHED,
    output logic [MISS_W-1:0] MISSED
);

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hlat;
    logic [VCNT_W-1:0] vcnt;
    logic [VCNT_W-1:0] vlat;
    logic              hde_q;
    logic              sen_edge;
    logic              pending;
    lg_state_t         state;
    lg_state_t         state_next;

    sync_rise #(
        .STAGES (SYNC_STAGES)
    ) u_sync_rise (
        .CLK      (CLK),
        .RESET    (RESET),
        .SENSOR   (SENSOR),
        .SEN_EDGE (sen_edge)
    );

    // Beam position: hcnt restarts on HDE rise, vcnt steps on HDE fall and
    // restarts during vertical blanking; both stick at their maximum.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hde_q <= 1'b0;
            hcnt  <= '0;
            vcnt  <= '0;
        end else if (CE_PIX) begin
            hde_q <= HDE;
            if (!hde_q && HDE) begin
                hcnt <= '0;
            end else if (hcnt != HCNT_MAX) begin
                hcnt <= hcnt + 1'b1;
            end
            if (hde_q && !HDE) begin
                if (!VDE) begin
                    vcnt <= '0;
                end else if (vcnt != VCNT_MAX) begin
                    vcnt <= vcnt + 1'b1;
                end
            end
        end
    end

    // Next-state logic; LATCH_EN low overrides every other transition.
    always_comb begin
        state_next = state;
        if (!LATCH_EN) begin
            state_next = DISABLED;
        end else begin
            case (state)
                DISABLED: state_next = ARMED;
                ARMED:    if (sen_edge) state_next = CAPTURED;
                CAPTURED: if (HV_RD) state_next = ARMED;
                default:  state_next = DISABLED;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= DISABLED;
        end else begin
            state <= state_next;
        end
    end

    // Freeze the beam position on the hit that moves ARMED into CAPTURED.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hlat <= '0;
            vlat <= '0;
        end else if (state == ARMED && state_next == CAPTURED) begin
            hlat <= hcnt;
            vlat <= vcnt;
        end
    end

    // Count hits that arrive while a capture is still unread; a read clears
    // the count and swallows any hit landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MISSED <= '0;
        end else if (state == CAPTURED) begin
            if (HV_RD) begin
                MISSED <= '0;
            end else if (sen_edge && MISSED != MISS_MAX) begin
                MISSED <= MISSED + 1'b1;
            end
        end
    end

    // Registered HV readback: frozen position while captured, live otherwise.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HV_OUT  <= '0;
            LATCHED <= 1'b0;
        end else begin
            if (state == CAPTURED) begin
                HV_OUT <= {vlat[7:0], hlat[8:1]};
            end else begin
                HV_OUT <= {vcnt[7:0], hcnt[8:1]};
            end
            LATCHED <= (state_next == CAPTURED);
        end
    end

    // Interrupt pending flag: any hit sets it, and a hit wins over a
    // simultaneous acknowledge so no hit is lost. IE2 only masks the request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending <= 1'b0;
            EXINT   <= 1'b0;
        end else begin
            if (sen_edge) begin
                pending <= 1'b1;
            end else if (INT_ACK) begin
                pending <= 1'b0;
            end
            EXINT <= pending & IE2;
        end
    end

endmodule

// File: tb/tb_lightgun_hv_latch.sv
// Directed bench for lightgun_hv_latch. The driver pushes expected output
// snapshots into a queue; the monitor pops them on the falling edge and
// compares against the DUT outputs.
module tb_lightgun_hv_latch;

    logic        clk;
    logic        reset;
    logic        ce_pix;
    logic        hde;
    logic        vde;
    logic        sensor;
    logic        latch_en;
    logic        ie2;
    logic        hv_rd;
    logic        int_ack;
    logic [15:0] hv_out;
    logic        exint;
    logic        latched;
    logic [3:0]  missed;

    // Expected entry: {mask[3:0], exint, missed[3:0], latched, hv[15:0]}
    // mask bits: 3 = hv_out, 2 = latched, 1 = missed, 0 = exint
    localparam int W = 26;
    logic [W-1:0] exp_q[$];
    string        name_q[$];

    int checks = 0;
    int errors = 0;

    lightgun_hv_latch #(
        .SYNC_STAGES (2),
        .MISS_W      (4)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .CE_PIX   (ce_pix),
        .HDE      (hde),
        .VDE      (vde),
        .SENSOR   (sensor),
        .LATCH_EN (latch_en),
        .IE2      (ie2),
        .HV_RD    (hv_rd),
        .INT_ACK  (int_ack),
        .HV_OUT   (hv_out),
        .EXINT    (exint),
        .LATCHED  (latched),
        .MISSED   (missed)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_chk(input string name, input logic [3:0] mask,
                              input logic [15:0] hv, input logic lat,
                              input logic [3:0] mis, input logic ex);
        exp_q.push_back({mask, ex, mis, lat, hv});
        name_q.push_back(name);
    endtask

    task automatic pix(input logic h, input logic v);
        hde    = h;
        vde    = v;
        ce_pix = 1'b1;
        tick(1);
        ce_pix = 1'b0;
    endtask

    // Drive the beam counters to hcnt = h, vcnt = v and leave them frozen.
    task automatic set_counters(input int h, input int v);
        pix(1'b1, 1'b0);
        pix(1'b0, 1'b0);
        for (int i = 0; i < v; i++) begin
            pix(1'b1, 1'b1);
            pix(1'b0, 1'b1);
        end
        pix(1'b1, 1'b1);
        for (int i = 0; i < h; i++) begin
            pix(1'b1, 1'b1);
        end
    endtask

    // One sensor pulse; returns one edge after the capture edge.
    task automatic pulse();
        sensor = 1'b1;
        tick(1);
        sensor = 1'b0;
        tick(3);
    endtask

    task automatic read_hv();
        hv_rd = 1'b1;
        tick(1);
        hv_rd = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (e[25]) begin
                checks++;
                if (hv_out !== e[15:0]) begin
                    errors++;
                    $display("FAIL %s hv_out: got %h want %h", n, hv_out, e[15:0]);
                end
            end
            if (e[24]) begin
                checks++;
                if (latched !== e[16]) begin
                    errors++;
                    $display("FAIL %s latched: got %b want %b", n, latched, e[16]);
                end
            end
            if (e[23]) begin
                checks++;
                if (missed !== e[20:17]) begin
                    errors++;
                    $display("FAIL %s missed: got %0d want %0d", n, missed, e[20:17]);
                end
            end
            if (e[22]) begin
                checks++;
                if (exint !== e[21]) begin
                    errors++;
                    $display("FAIL %s exint: got %b want %b", n, exint, e[21]);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        reset    = 1'b1;
        ce_pix   = 1'b0;
        hde      = 1'b0;
        vde      = 1'b0;
        sensor   = 1'b0;
        latch_en = 1'b0;
        ie2      = 1'b0;
        hv_rd    = 1'b0;
        int_ack  = 1'b0;
        tick(2);
        expect_chk("reset_state", 4'hF, 16'h0000, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;

        // Capture at hcnt=200, vcnt=100
        latch_en = 1'b1;
        set_counters(200, 100);
        pulse();
        expect_chk("capture", 4'hF, 16'h6464, 1'b1, 4'd0, 1'b0);
        pix(1'b1, 1'b1);
        pix(1'b1, 1'b1);
        pix(1'b1, 1'b1);
        expect_chk("capture_hold", 4'hC, 16'h6464, 1'b1, 4'd0, 1'b0);

        // Lockout: extra hits only count
        pulse();
        pulse();
        pulse();
        expect_chk("lockout", 4'hE, 16'h6464, 1'b1, 4'd3, 1'b0);
        read_hv();
        expect_chk("read_same_edge", 4'hE, 16'h6464, 1'b0, 4'd0, 1'b0);
        tick(1);
        expect_chk("read_live", 4'h8, 16'h6465, 1'b0, 4'd0, 1'b0);
        set_counters(10, 5);
        pulse();
        expect_chk("recapture", 4'hE, 16'h0505, 1'b1, 4'd0, 1'b0);
        read_hv();

        // Interrupt with latch disabled
        latch_en = 1'b0;
        ack();
        tick(1);
        ie2 = 1'b1;
        tick(1);
        expect_chk("int_idle", 4'hD, 16'h0505, 1'b0, 4'd0, 1'b0);
        pix(1'b1, 1'b1);
        pix(1'b1, 1'b1);
        pulse();
        expect_chk("int_set", 4'hF, 16'h0506, 1'b0, 4'd0, 1'b1);
        sensor = 1'b1;
        tick(1);
        sensor = 1'b0;
        tick(1);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tick(1);
        expect_chk("int_edge_wins", 4'h1, 16'h0000, 1'b0, 4'd0, 1'b1);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        expect_chk("int_ack_lag", 4'h1, 16'h0000, 1'b0, 4'd0, 1'b1);
        tick(1);
        expect_chk("int_cleared", 4'h1, 16'h0000, 1'b0, 4'd0, 1'b0);

        // Masking
        ie2 = 1'b0;
        pulse();
        expect_chk("mask_low", 4'h1, 16'h0000, 1'b0, 4'd0, 1'b0);
        ie2 = 1'b1;
        tick(1);
        expect_chk("mask_raise", 4'h1, 16'h0000, 1'b0, 4'd0, 1'b1);
        ack();
        tick(1);

        // Saturation: missed counter and hcnt
        latch_en = 1'b1;
        tick(1);
        pulse();
        for (int i = 0; i < 20; i++) begin
            pulse();
        end
        expect_chk("missed_sat", 4'hE, 16'h0506, 1'b1, 4'd15, 1'b0);
        read_hv();
        tick(1);
        hde    = 1'b1;
        ce_pix = 1'b1;
        tick(520);
        ce_pix = 1'b0;
        tick(1);
        expect_chk("hcnt_sat", 4'hE, 16'h05FF, 1'b0, 4'd0, 1'b0);

        // Reset with sensor held high
        reset    = 1'b1;
        sensor   = 1'b1;
        latch_en = 1'b1;
        tick(3);
        expect_chk("reset_hold", 4'hF, 16'h0000, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        tick(6);
        expect_chk("reset_release", 4'hF, 16'h0000, 1'b0, 4'd0, 1'b0);
        set_counters(10, 5);
        sensor = 1'b0;
        tick(3);
        pulse();
        expect_chk("armed_after_reset", 4'hC, 16'h0505, 1'b1, 4'd0, 1'b0);
        reset = 1'b1;
        tick(1);
        expect_chk("reset_in_capture", 4'hF, 16'h0000, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        tick(2);
        expect_chk("after_reset_live", 4'hC, 16'h0000, 1'b0, 4'd0, 1'b0);
        tick(2);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lightgun_hv_latch.md
LIGHTGUN_HV_LATCH -- requirements
Module: lightgun_hv_latch

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of SENSOR synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter MISS_W, default 4, giving the width of the missed-edge counter.
REQ-003 CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 CE_PIX  input  1  pixel clock enable.
REQ-006 HDE  input  1  horizontal display enable.
REQ-007 VDE  input  1  vertical display enable.
REQ-008 SENSOR  input  1  light gun sensor, active-high, asynchronous to CLK.
REQ-009 LATCH_EN  input  1  HV latch enable (VDP mode bit M3).
REQ-010 IE2  input  1  external interrupt enable.
REQ-011 HV_RD  input  1  one-CLK HV counter read strobe.
REQ-012 INT_ACK  input  1  one-CLK external interrupt acknowledge.
REQ-013 HV_OUT  output  16  {V[7:0], H[8:1]} value returned to the CPU.
REQ-014 EXINT  output  1  external interrupt request, level.
REQ-015 LATCHED  output  1  high while state is CAPTURED.
REQ-016 MISSED  output  MISS_W  sensor edges dropped while CAPTURED.

Function
REQ-017 The hcnt counter (9 bits) SHALL, on CE_PIX, load 0 when the previous HDE sample is 0 and HDE is 1; otherwise it SHALL increment, saturating at 511.
REQ-018 The vcnt counter (9 bits) SHALL, on CE_PIX with an HDE falling edge, load 0 if VDE is 0; otherwise it SHALL increment, saturating at 511.
REQ-019 SENSOR SHALL pass through SYNC_STAGES flops. A rising edge (sen_edge) SHALL be a one-CLK pulse when the synchronized value is 1 and its previous value is 0. Edge detection is evaluated every CLK, independent of CE_PIX.
REQ-020 FSM states:
- DISABLED: LATCH_EN=1 -> ARMED.
- ARMED: sen_edge -> CAPTURED, with hlat<=hcnt and vlat<=vcnt.
- CAPTURED: HV_RD -> ARMED.
- LATCH_EN=0 in any state -> DISABLED; this has priority over all other transitions.
REQ-021 A sen_edge while in DISABLED SHALL NOT capture, including the cycle in which LATCH_EN first rises.
REQ-022 A sen_edge while in CAPTURED SHALL NOT overwrite hlat/vlat. It SHALL increment MISSED, saturating at all-ones.
REQ-023 HV_RD in CAPTURED SHALL clear MISSED. A sen_edge in the same cycle SHALL be dropped and SHALL NOT be counted.
REQ-024 HV_OUT SHALL be registered with 1-CLK latency:
- CAPTURED: {vlat[7:0], hlat[8:1]}.
- Otherwise: {vcnt[7:0], hcnt[8:1]}.
REQ-025 HV_RD SHALL NOT alter HV_OUT in the cycle it is presented; the register updates on the following edge.
REQ-026 An internal pending flag SHALL set on every sen_edge, regardless of FSM state or LATCH_EN. It SHALL clear on INT_ACK. If sen_edge and INT_ACK occur in the same cycle, the flag SHALL remain set.
REQ-027 EXINT SHALL equal pending AND IE2, registered. Clearing IE2 masks EXINT but SHALL NOT clear pending.
REQ-028 LATCHED SHALL be registered, equal to (next state == CAPTURED).

Reset
REQ-029 While RESET=1, on each CLK:
- FSM -> DISABLED.
- hcnt, vcnt, hlat, vlat, pending, MISSED, HV_OUT, EXINT, LATCHED -> 0.
- Synchronizer flops and the edge-history flop -> 1, so a SENSOR already high at reset release produces no edge.
REQ-030 Reset asserted mid-capture SHALL discard the latched values, and SHALL hold priority over all other inputs.

Structure
REQ-031 Package lightgun_hv_latch_pkg SHALL hold the FSM state enum (DISABLED, ARMED, CAPTURED) and the constants HCNT_W=9, VCNT_W=9, HV_W=16.
REQ-032 One sub-module, sync_rise, SHALL implement the SYNC_STAGES synchronizer and rising-edge detector. Counters, FSM and interrupt logic SHALL live in the top module.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Capture: LATCH_EN=1; SENSOR rises when hcnt=200, vcnt=100 -> HV_OUT=0x6464 from 1 CLK after CAPTURED until HV_RD, and LATCHED=1.
- Lockout: in CAPTURED, apply 3 SENSOR pulses -> HV_OUT unchanged and MISSED=3. HV_RD -> MISSED=0 and ARMED. The next pulse at hcnt=10, vcnt=5 -> HV_OUT=0x0505.
- Interrupt: IE2=1, LATCH_EN=0, one SENSOR pulse -> EXINT=1 with HV_OUT live. INT_ACK on the same cycle as a second sen_edge -> EXINT stays 1. A lone INT_ACK -> EXINT=0.
- Masking: IE2=0 with a SENSOR pulse -> EXINT=0. Raise IE2 -> EXINT=1 the next CLK.
- Reset: SENSOR held 1 through RESET, LATCH_EN=1 -> after release, state reaches ARMED, no capture and EXINT=0. RESET during CAPTURED -> HV_OUT=0 and LATCHED=0.
- Saturation: 20 edges in CAPTURED -> MISSED=15. hcnt held without HDE rise -> saturates at 511, so HV_OUT[7:0]=0xFF.
